// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: latch enables/flushes,
// EX forwarding selects, load-use sequencer, dcache watchdog, perf counters.
module hazard_ctrl_unit #(
  parameter int REG_W     = 5,
  parameter int FWD_EN    = 1,
  parameter int LU_CYCLES = 1,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rw,
  input  logic             ex_wen,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rw,
  input  logic             mem_wen,
  input  logic [REG_W-1:0] wb_rw,
  input  logic             wb_wen,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int FW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] TO = FW'(TIMEOUT);
  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

  typedef enum logic {RUN, STALL} state_e;

  state_e           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [FW-1:0]    frz_cnt_q, frz_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze;
  logic ex_match;
  logic mem_match;
  logic raw;
  logic stall;

  function automatic logic hit(input logic [REG_W-1:0] a,
                               input logic [REG_W-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  assign freeze = (mem_dREN | mem_dWEN) & ~dhit;

  assign ex_match = ex_wen &
    (hit(ex_rw, id_rs) | (id_uses_rt & hit(ex_rw, id_rt)));
  assign mem_match = mem_wen &
    (hit(mem_rw, id_rs) | (id_uses_rt & hit(mem_rw, id_rt)));

  assign raw = (FWD_EN != 0) ? (ex_memread & ex_match)
                             : (ex_match | mem_match);

  assign stall = (state_q == STALL) | raw;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (mem_wen && hit(mem_rw, ex_rs))     fwd_a = 2'b10;
      else if (wb_wen && hit(wb_rw, ex_rs))  fwd_a = 2'b01;
      if (mem_wen && hit(mem_rw, ex_rt))     fwd_b = 2'b10;
      else if (wb_wen && hit(wb_rw, ex_rt))  fwd_b = 2'b01;
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    if (freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      lu_cnt_d   = 3'd0;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (state_q == RUN) begin
        // this cycle is bubble 1; the rest come from STALL
        if (LU_CYCLES > 1) begin
          state_d  = STALL;
          lu_cnt_d = LU_INIT;
        end
      end else if (lu_cnt_q <= 3'd1) begin
        state_d  = RUN;
        lu_cnt_d = 3'd0;
      end else begin
        lu_cnt_d = lu_cnt_q - 3'd1;
      end
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    frz_cnt_d = '0;
    if (freeze) begin
      frz_cnt_d = (frz_cnt_q >= TO) ? frz_cnt_q : frz_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (frz_cnt_d >= TO);
    stall_d   = stall_q;
    flush_d   = flush_q;
    if (!freeze && !pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (!freeze && ex_redirect && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      lu_cnt_q  <= 3'd0;
      frz_cnt_q <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      lu_cnt_q  <= lu_cnt_d;
      frz_cnt_q <= frz_cnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor hazard controller for the 5-stage pipelined MIPS datapath (IF/ID/EX/MEM/WB).
- Produces per-latch enables and flushes, and EX-stage forwarding selects.
- Adds a forwarding/no-forwarding mode, a multi-cycle load-use stall sequencer, a dcache-wait watchdog, and saturating stall/flush performance counters.
- Sits beside the pipeline latches; the datapath top level consumes every output.

Parameters:
REG_W, 5, register index width (regbits_t)
FWD_EN, 1, 1 = forwarding plus load-use stall only; 0 = stall on any RAW hazard against EX/MEM
LU_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
TIMEOUT, 255, consecutive freeze cycles before mem_timeout sets
CNT_W, 16, performance counter width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  icache hit
dhit  in  1  dcache hit
mem_dREN  in  1  MEM-stage load
mem_dWEN  in  1  MEM-stage store
id_rs  in  REG_W  ID source A
id_rt  in  REG_W  ID source B
id_uses_rt  in  1  ID instruction reads rt
ex_rs  in  REG_W  EX source A
ex_rt  in  REG_W  EX source B
ex_rw  in  REG_W  EX destination
ex_wen  in  1  EX writes a register
ex_memread  in  1  EX instruction is a load
mem_rw  in  REG_W  MEM destination
mem_wen  in  1  MEM writes a register
wb_rw  in  REG_W  WB destination
wb_wen  in  1  WB writes a register
ex_redirect  in  1  taken branch or jump resolved in EX
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID enable
idex_en  out  1  ID/EX enable
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
ifid_flush  out  1  IF/ID bubble
idex_flush  out  1  ID/EX bubble
fwd_a  out  2  EX operand A select: 00 regfile, 01 WB, 10 MEM
fwd_b  out  2  EX operand B select, same encoding
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0
flush_events  out  CNT_W  saturating count of ex_redirect actions

Behaviour:
- Register 0 never matches for hazard or forwarding.

Combinational signals:
- freeze = (mem_dREN|mem_dWEN) & !dhit.
- raw:
  - FWD_EN=1: ex_memread & ex_wen & (ex_rw==id_rs | id_uses_rt & ex_rw==id_rt).
  - FWD_EN=0: the same match against (ex_wen, ex_rw) or (mem_wen, mem_rw), with no load qualifier.
- fwd_a: 10 if mem_wen & mem_rw==ex_rs; else 01 if wb_wen & wb_rw==ex_rs; else 00. MEM takes priority. fwd_b is the same using ex_rt. Both are forced to 00 when FWD_EN=0.

Priority of actions each cycle:
1. freeze
   - All five enables 0; both flushes 0.
   - Counters and FSM hold, except the watchdog.
2. ex_redirect
   - pc_en=1, ifid_flush=1, idex_flush=1, all other enables 1.
   - FSM goes to RUN; flush_events increments.
3. stall (FSM in STALL, or raw in RUN)
   - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
4. !ihit
   - pc_en=0, ifid_flush=1, all other enables 1.
5. Otherwise all enables 1, flushes 0.

FSM, states RUN and STALL, with a 3-bit down-counter lu_cnt:
- RUN & raw & no freeze/redirect: the current cycle is bubble 1.
  - LU_CYCLES=1 stays in RUN.
  - Otherwise enter STALL with lu_cnt=LU_CYCLES-1.
- STALL: decrement lu_cnt each unfrozen cycle; leave for RUN in the cycle lu_cnt==1.
- STALL & redirect: RUN immediately.
- STALL & freeze: hold lu_cnt.
- FWD_EN=0: raw re-evaluates every cycle in RUN, so the stall lasts until the writer leaves MEM.

Watchdog and counters:
- frz_cnt increments on consecutive freeze cycles and clears when freeze is low.
- mem_timeout sets when frz_cnt reaches TIMEOUT, and stays set until reset.
- stall_cycles and flush_events saturate at all-ones and never wrap.

Reset (nRST low, asynchronous):
- FSM=RUN; lu_cnt, frz_cnt, mem_timeout and both counters = 0.
- Combinational outputs follow their inputs immediately.
- Reset asserted mid-STALL abandons the stall; there is no residual bubble after release.

Test Plan:
- FWD_EN=1: EX lw $3, ID add rs=$3 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1.
- LU_CYCLES=3, same load-use pair -> 3 consecutive bubble cycles; dhit=0 for 2 cycles in the middle freezes everything, then the remaining bubbles resume; total pc_en=0 cycles = 5.
- mem_rw=wb_rw=$5, both wen, ex_rs=$5, ex_rt=$0 -> fwd_a=10, fwd_b=00; with mem_wen=0 -> fwd_a=01.
- FWD_EN=0: EX add $4 then ID uses $4 -> 2 stall cycles (writer in EX, then MEM); fwd_a/fwd_b stay 00.
- ex_redirect concurrent with raw in STALL -> ifid_flush=idex_flush=1, pc_en=1, FSM returns to RUN; flush_events +1.
- TIMEOUT=4, mem_dREN=1 and dhit=0 held for 6 cycles -> mem_timeout rises after the 4th freeze cycle and stays high after dhit returns; nRST low clears it asynchronously.
